// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch-stage state encoding, constants and the branch
// target helper used by both the RTL and anything that models it.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

  // MOV r0,r0 - harmless filler presented while the output is not valid
  localparam logic [31:0] NOP_WORD = 32'hE1A0_0000;

  // ALU codes of the two branch flavours resolved in execute
  localparam logic [5:0] ALU_B  = 6'd31;
  localparam logic [5:0] ALU_BL = 6'd32;

  // Branch target: pipeline PC (instruction address + 8) plus the signed
  // 24-bit word offset scaled to bytes; wraps modulo 2^32.
  function automatic logic [31:0] branch_target(input logic [31:0] pc,
                                                input logic [23:0] imm24);
    return pc + 32'd8 + {{6{imm24[23]}}, imm24, 2'b00};
  endfunction

endpackage

// File: rtl/branch_target_calc.sv
// branch_target_calc: combinational sign-extend / shift / add producing the
// redirect address from the branch instruction's own address.
module branch_target_calc (
  input  logic [31:0] pc,
  input  logic [23:0] imm24,
  output logic [31:0] target
);
  import cpu_pkg::*;

  assign target = branch_target(pc, imm24);

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: owns the PC, reads instruction memory over a req/ack
// handshake and drives the decoder's instruction register. Branch redirects
// arrive one stage later and squash any wrong-path word still in flight.
// Optional build macro INSTRUCTION_FETCH_PREFETCH_EN lets the fetch continue
// while the output is stalled, parking the word in the HOLD buffer so it is
// presented on the very edge the stall releases.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'hE1A0_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_taken,
  input  logic        br_link,
  input  logic [23:0] br_address,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction_set,
  output logic        instr_valid,
  output logic [31:0] instr_pc,
  output logic        link_wr,
  output logic [31:0] link_data
);
  import cpu_pkg::*;

  fetch_state_t state_reg, state_next;
  logic [31:0]  pc_reg, pc_next;
  logic [31:0]  addr_reg, addr_next;
  logic         squash_reg, squash_next;
  logic [31:0]  hold_word_reg, hold_word_next;
  logic [31:0]  instr_reg, instr_next;
  logic         valid_reg, valid_next;
  logic [31:0]  instr_pc_reg, instr_pc_next;
  logic         link_wr_reg, link_wr_next;
  logic [31:0]  link_data_reg, link_data_next;
  logic [31:0]  target;
  logic         redirect;

  branch_target_calc u_target (
    .pc     (instr_pc_reg),
    .imm24  (br_address),
    .target (target)
  );

  // A branch seen during a stall is dropped; upstream repeats it afterwards
  assign redirect = br_taken & ~stall;

  // The address of an outstanding read stays frozen even if a redirect
  // moves the PC underneath it
  assign imem_addr       = (state_reg == WAIT) ? addr_reg : pc_reg;
  assign instruction_set = instr_reg;
  assign instr_valid     = valid_reg;
  assign instr_pc        = instr_pc_reg;
  assign link_wr         = link_wr_reg;
  assign link_data       = link_data_reg;

  // Next-state, request and output-register update logic
  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    addr_next      = addr_reg;
    squash_next    = squash_reg;
    hold_word_next = hold_word_reg;
    instr_next     = instr_reg;
    valid_next     = valid_reg;
    instr_pc_next  = instr_pc_reg;
    link_wr_next   = 1'b0;
    link_data_next = link_data_reg;
    imem_req       = 1'b0;

    case (state_reg)
      IDLE: state_next = REQ;
      REQ: begin
`ifdef INSTRUCTION_FETCH_PREFETCH_EN
        imem_req = 1'b1;
`else
        imem_req = ~(stall & valid_reg);
`endif
        addr_next = pc_reg;
        if (imem_req) state_next = WAIT;
      end
      WAIT: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          if (squash_reg) begin
            squash_next = 1'b0;
            state_next  = REQ;
          end else if (stall) begin
            hold_word_next = imem_rdata;
            state_next     = HOLD;
          end else begin
            instr_next    = imem_rdata;
            valid_next    = 1'b1;
            instr_pc_next = pc_reg;
            pc_next       = pc_reg + 32'd4;
            state_next    = REQ;
          end
        end
      end
      HOLD: begin
        if (!stall) begin
          instr_next    = hold_word_reg;
          valid_next    = 1'b1;
          instr_pc_next = pc_reg;
          pc_next       = pc_reg + 32'd4;
          state_next    = REQ;
        end
      end
      default: state_next = IDLE;
    endcase

    // Redirect overrides everything above, including a same-cycle ack
    if (redirect) begin
      pc_next    = target;
      valid_next = 1'b0;
      instr_next = NOP_WORD;
      if (state_reg == WAIT && !imem_ack) begin
        squash_next = 1'b1;
        state_next  = WAIT;
      end else begin
        squash_next = 1'b0;
        state_next  = REQ;
      end
      if (br_link) begin
        link_wr_next   = 1'b1;
        link_data_next = instr_pc_reg + 32'd4;
      end
    end
  end

  // State and output registers with asynchronous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      pc_reg        <= RESET_PC;
      addr_reg      <= RESET_PC;
      squash_reg    <= 1'b0;
      hold_word_reg <= NOP_WORD;
      instr_reg     <= NOP_WORD;
      valid_reg     <= 1'b0;
      instr_pc_reg  <= 32'd0;
      link_wr_reg   <= 1'b0;
      link_data_reg <= 32'd0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      addr_reg      <= addr_next;
      squash_reg    <= squash_next;
      hold_word_reg <= hold_word_next;
      instr_reg     <= instr_next;
      valid_reg     <= valid_next;
      instr_pc_reg  <= instr_pc_next;
      link_wr_reg   <= link_wr_next;
      link_data_reg <= link_data_next;
    end
  end

endmodule
